// File: rtl/img_arb_pkg.sv
// Shared constants for the image read-port arbiter.
// State encoding is kept as plain 1-bit constants for legacy tools.
package img_arb_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 8;
    localparam int IMG_W  = 128;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Wrap an index to the next requester modulo n.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/img_rd_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after i_start,
// wrapping modulo N. Returns one-hot grant, its index and a found flag.
module rr_pick
    import img_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_c;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_c   = i_start;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_idx      = w_c;
                o_gnt[w_c] = 1'b1;
            end
            w_c = IW'(wrap_inc(int'(w_c), N));
        end
    end

endmodule

// File: rtl/img_rd_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency image read port
// between N_REQ requesters, with optional bounded burst lock.
module img_rd_arbiter
    import img_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ*AW-1:0] addr_in,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic [AW-1:0]       iaddr,
    input  logic [DW-1:0]       idata,
    output logic                busy
);

    localparam int IW = $clog2(N_REQ);

    logic [0:0]       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [3:0]       r_cnt;
    logic [AW-1:0]    r_iaddr;
    logic [N_REQ-1:0] r_rvalid;

    logic [0:0]       w_state_n;
    logic [IW-1:0]    w_ptr_n;
    logic [IW-1:0]    w_owner_n;
    logic [3:0]       w_cnt_n;

    logic [IW-1:0]    w_owner_nxt;
    logic [IW-1:0]    w_start;
    logic             w_hold;
    logic [N_REQ-1:0] w_owner_oh;
    logic [N_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]    w_pick_idx;
    logic [IW-1:0]    w_pick_nxt;
    logic             w_pick_any;
    logic [IW-1:0]    w_idx;
    logic [AW-1:0]    w_addr;
    logic             w_acc;
    logic [3:0]       w_cnt_inc;
    logic             w_force;
    logic             w_lock_new;

    assign w_owner_nxt = IW'(wrap_inc(int'(r_owner), N_REQ));
    assign w_pick_nxt  = IW'(wrap_inc(int'(w_pick_idx), N_REQ));
    assign w_hold      = (r_state == ST_LOCKED) && req[r_owner];
    // A dropped lock searches from just past the old owner.
    assign w_start     = (r_state == ST_LOCKED) ? w_owner_nxt : r_ptr;
    assign w_owner_oh  = N_REQ'(1) << r_owner;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        gnt = '0;
        if (reset) begin
            gnt = w_hold ? w_owner_oh : w_pick_gnt;
        end
    end

    assign w_acc      = |gnt;
    assign w_idx      = w_hold ? r_owner : w_pick_idx;
    assign w_cnt_inc  = r_cnt + 4'd1;
    assign w_force    = (w_cnt_inc >= 4'(MAX_BURST));
    assign w_lock_new = lock[w_pick_idx] && (MAX_BURST > 1);

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == IW'(i)) begin
                w_addr = addr_in[i*AW +: AW];
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_owner_n = r_owner;
        w_cnt_n   = r_cnt;
        if (w_hold) begin
            if (!lock[r_owner] || w_force) begin
                w_state_n = ST_ARB;
                w_ptr_n   = w_owner_nxt;
                w_cnt_n   = '0;
            end else begin
                w_cnt_n = w_cnt_inc;
            end
        end else begin
            w_state_n = ST_ARB;
            w_cnt_n   = '0;
            w_ptr_n   = w_start;
            if (w_pick_any) begin
                if (w_lock_new) begin
                    w_state_n = ST_LOCKED;
                    w_owner_n = w_pick_idx;
                    w_cnt_n   = 4'd1;
                end else begin
                    w_ptr_n = w_pick_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_ARB;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_iaddr  <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_state_n;
            r_ptr    <= w_ptr_n;
            r_owner  <= w_owner_n;
            r_cnt    <= w_cnt_n;
            r_rvalid <= gnt;
            if (w_acc) begin
                r_iaddr <= w_addr;
            end
        end
    end

    assign iaddr  = r_iaddr;
    assign rvalid = r_rvalid;
    assign rdata  = idata;
    assign busy   = (r_state == ST_LOCKED) | (|r_rvalid) | (|(req & gnt));

endmodule

// File: tb/tb_img_rd_arbiter.sv
// Directed and randomized checks for img_rd_arbiter with a
// behavioural 1-cycle-latency image memory.
module tb_img_rd_arbiter;

    localparam int N  = 2;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int MB = 9;
    localparam int BOUND = (N - 1) * MB;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   iaddr;
    logic [DW-1:0]   idata;
    logic            busy;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int tests = 0;
    int fails = 0;

    img_rd_arbiter #(
        .N_REQ     (N),
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .addr_in (addr_in),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .iaddr   (iaddr),
        .idata   (idata),
        .busy    (busy)
    );

    assign idata = mem[iaddr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_addr(input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1);
        addr_in = {a1, a0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 2'b11;
        lock  = 2'b00;
        set_addr(14'h0010, 14'h0020);
        #2;
        tests++;
        if (gnt !== 2'b00) begin
            fails++;
            $display("FAIL reset_gnt got=%b want=00", gnt);
        end
        tests++;
        if (rvalid !== 2'b00) begin
            fails++;
            $display("FAIL reset_rvalid got=%b want=00", rvalid);
        end
        tests++;
        if (iaddr !== 14'h0) begin
            fails++;
            $display("FAIL reset_iaddr got=%h want=0000", iaddr);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        req   = '0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req  = 2'b01;
        lock = 2'b00;
        set_addr(14'h0081, 14'h0000);
        #1;
        tests++;
        if (gnt !== 2'b01) begin
            fails++;
            $display("FAIL single_gnt got=%b want=01", gnt);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rvalid !== 2'b01 || rdata !== 8'h5A || iaddr !== 14'h0081) begin
            fails++;
            $display("FAIL single_read got=%b/%h/%h want=01/5a/0081",
                     rvalid, rdata, iaddr);
        end
        // ptr has moved to 1, so requester 1 now wins a tie
        @(negedge clk);
        req = 2'b11;
        set_addr(14'h0082, 14'h0083);
        #1;
        tests++;
        if (gnt !== 2'b10) begin
            fails++;
            $display("FAIL rr_after_single got=%b want=10", gnt);
        end
        @(negedge clk);
        req = 2'b00;
        #1;
        tests++;
        if (gnt !== 2'b00) begin
            fails++;
            $display("FAIL idle_gnt got=%b want=00", gnt);
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0]  exp_g;
        logic [AW-1:0] a;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req  = 2'b11;
            lock = 2'b00;
            set_addr(14'h0100 + AW'(k), 14'h0200 + AW'(k));
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            a     = (k % 2 == 0) ? 14'h0100 + AW'(k) : 14'h0200 + AW'(k);
            #1;
            tests++;
            if (gnt !== exp_g) begin
                fails++;
                $display("FAIL alt_gnt[%0d] got=%b want=%b", k, gnt, exp_g);
            end
            @(posedge clk);
            #1;
            tests++;
            if (rvalid !== exp_g || rdata !== mem[a]) begin
                fails++;
                $display("FAIL alt_read[%0d] got=%b/%h want=%b/%h",
                         k, rvalid, rdata, exp_g, mem[a]);
            end
        end
        @(negedge clk);
        req = 2'b00;
    endtask

    task automatic test_burst();
        logic [N-1:0]  exp_g;
        logic [AW-1:0] a;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req  = 2'b11;
            lock = 2'b01;
            set_addr(14'h0300 + AW'(k), 14'h03F0);
            exp_g = (k < MB) ? 2'b01 : 2'b10;
            a     = (k < MB) ? 14'h0300 + AW'(k) : 14'h03F0;
            #1;
            tests++;
            if (gnt !== exp_g) begin
                fails++;
                $display("FAIL burst_gnt[%0d] got=%b want=%b", k, gnt, exp_g);
            end
            @(posedge clk);
            #1;
            tests++;
            if (rvalid !== exp_g || rdata !== mem[a]) begin
                fails++;
                $display("FAIL burst_read[%0d] got=%b/%h want=%b/%h",
                         k, rvalid, rdata, exp_g, mem[a]);
            end
        end
        @(negedge clk);
        req  = 2'b00;
        lock = 2'b00;
    endtask

    task automatic test_drop();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req  = 2'b11;
            lock = 2'b01;
            set_addr(14'h0500 + AW'(k), 14'h0600);
            #1;
            tests++;
            if (gnt !== 2'b01) begin
                fails++;
                $display("FAIL drop_lock_gnt[%0d] got=%b want=01", k, gnt);
            end
        end
        @(negedge clk);
        req = 2'b10;
        #1;
        tests++;
        if (gnt !== 2'b10) begin
            fails++;
            $display("FAIL drop_handover got=%b want=10", gnt);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rvalid !== 2'b10 || rdata !== mem[14'h0600]) begin
            fails++;
            $display("FAIL drop_read got=%b/%h want=10/%h",
                     rvalid, rdata, mem[14'h0600]);
        end
        @(negedge clk);
        req  = 2'b00;
        lock = 2'b00;
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || rvalid !== 2'b00) begin
            fails++;
            $display("FAIL drop_unlocked busy/rvalid got=%b/%b want=0/00",
                     busy, rvalid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req  = 2'b11;
            lock = 2'b01;
            set_addr(14'h0400 + AW'(k), 14'h0700);
        end
        @(negedge clk);
        set_addr(14'h0403, 14'h0700);
        #1;
        tests++;
        if (gnt !== 2'b01 || rvalid !== 2'b01) begin
            fails++;
            $display("FAIL mid_beat4 gnt/rvalid got=%b/%b want=01/01",
                     gnt, rvalid);
        end
        #1;
        reset = 1'b0;
        #1;
        tests++;
        if (gnt !== 2'b00 || rvalid !== 2'b00 || iaddr !== 14'h0) begin
            fails++;
            $display("FAIL mid_reset got=%b/%b/%h want=00/00/0000",
                     gnt, rvalid, iaddr);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_busy got=%b want=0", busy);
        end
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b11;
        lock  = 2'b00;
        #1;
        tests++;
        if (gnt !== 2'b01) begin
            fails++;
            $display("FAIL mid_retry0 got=%b want=01", gnt);
        end
        @(negedge clk);
        #1;
        tests++;
        if (gnt !== 2'b10) begin
            fails++;
            $display("FAIL mid_retry1 got=%b want=10", gnt);
        end
        @(negedge clk);
        req = 2'b00;
    endtask

    task automatic test_random();
        logic [N-1:0]  rq;
        logic [AW-1:0] ra [N];
        int            wt [N];
        logic [N-1:0]  g;
        logic [N-1:0]  exp_v;
        logic [DW-1:0] exp_d;
        do_reset();
        rq = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            wt[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(0, 1) == 0) begin
                    rq[i] = 1'b1;
                    ra[i] = AW'($urandom);
                end
                lock[i] = ($urandom_range(0, 3) != 0);
            end
            req = rq;
            set_addr(ra[0], ra[1]);
            #1;
            g = gnt;
            tests++;
            if (((g & (g - 1'b1)) != '0) || ((g & ~rq) != '0)) begin
                fails++;
                $display("FAIL rand_onehot[%0d] gnt=%b req=%b", c, g, rq);
            end
            exp_v = g;
            exp_d = g[1] ? mem[ra[1]] : mem[ra[0]];
            for (int i = 0; i < N; i++) begin
                if (rq[i] && !g[i]) wt[i]++;
                else wt[i] = 0;
                tests++;
                if (wt[i] > BOUND) begin
                    fails++;
                    $display("FAIL rand_starve[%0d] req%0d waited=%0d max=%0d",
                             c, i, wt[i], BOUND);
                end
                if (g[i]) begin
                    rq[i] = ($urandom_range(0, 3) != 0);
                    ra[i] = AW'($urandom);
                end
            end
            @(posedge clk);
            #1;
            tests++;
            if (rvalid !== exp_v || (exp_v != '0 && rdata !== exp_d)) begin
                fails++;
                $display("FAIL rand_read[%0d] got=%b/%h want=%b/%h",
                         c, rvalid, rdata, exp_v, exp_d);
            end
        end
        @(negedge clk);
        req  = '0;
        lock = '0;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a] = 8'((a * 5) ^ (a >> 7));
        end
        mem[14'h0081] = 8'h5A;
        req     = '0;
        lock    = '0;
        addr_in = '0;
        reset   = 1'b0;

        test_reset();
        test_single();
        test_alternate();
        test_burst();
        test_drop();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
